// File: rtl/vga_pkg.sv
// Shared VGA 640x480@60 timing constants, control-bit payload and decode helper.
// Optional frame counter is enabled by defining VGA_FRAME_CNT_EN.
package vga_pkg;

  localparam int unsigned COORD_W   = 10;

  localparam int unsigned H_VISIBLE = 640;
  localparam int unsigned H_FP      = 16;
  localparam int unsigned H_SYNC    = 96;
  localparam int unsigned H_BP      = 48;
  localparam int unsigned H_TOTAL   = H_VISIBLE + H_FP + H_SYNC + H_BP;

  localparam int unsigned V_VISIBLE = 480;
  localparam int unsigned V_FP      = 10;
  localparam int unsigned V_SYNC    = 2;
  localparam int unsigned V_BP      = 33;
  localparam int unsigned V_TOTAL   = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam int unsigned H_SYNC_START = H_VISIBLE + H_FP;
  localparam int unsigned H_SYNC_END   = H_SYNC_START + H_SYNC - 1;
  localparam int unsigned V_SYNC_START = V_VISIBLE + V_FP;
  localparam int unsigned V_SYNC_END   = V_SYNC_START + V_SYNC - 1;

`ifdef VGA_FRAME_CNT_EN
  localparam int unsigned FRAME_CNT_W = 8;
`endif

  typedef struct packed {
    logic hsync;
    logic vsync;
    logic nocolor;
  } vga_ctrl_t;

  // Sync/blank levels for a given coordinate pair.
  function automatic vga_ctrl_t vga_decode(input logic [COORD_W-1:0] x,
                                           input logic [COORD_W-1:0] y);
    vga_ctrl_t d;
    d.hsync   = !((x >= COORD_W'(H_SYNC_START)) && (x <= COORD_W'(H_SYNC_END)));
    d.vsync   = !((y >= COORD_W'(V_SYNC_START)) && (y <= COORD_W'(V_SYNC_END)));
    d.nocolor = (x >= COORD_W'(H_VISIBLE)) || (y >= COORD_W'(V_VISIBLE));
    return d;
  endfunction

endpackage

// File: rtl/vga_if.sv
// Timing bundle from vga_timing to the pixel pipeline.
// frame_cnt exists only when VGA_FRAME_CNT_EN is defined.
interface vga_if;
  import vga_pkg::*;

  logic [COORD_W-1:0] xcoord;
  logic [COORD_W-1:0] ycoord;
  logic               nocolor;
  logic               hsync;
  logic               vsync;
  logic               frame_start;
`ifdef VGA_FRAME_CNT_EN
  logic [FRAME_CNT_W-1:0] frame_cnt;
`endif

  modport master (
    output xcoord, ycoord, nocolor, hsync, vsync, frame_start
`ifdef VGA_FRAME_CNT_EN
    , output frame_cnt
`endif
  );

  modport slave (
    input xcoord, ycoord, nocolor, hsync, vsync, frame_start
`ifdef VGA_FRAME_CNT_EN
    , input frame_cnt
`endif
  );

endinterface

// File: rtl/vga_wrap_counter.sv
// Enabled modulo-(MAX+1) counter with synchronous active-low clear.
// Exposes its next value so downstream decode can be registered in step with it.
module vga_wrap_counter #(
  parameter int unsigned W   = 10,
  parameter int unsigned MAX = 799
) (
  input  logic         clk,
  input  logic         clr_n,
  input  logic         en,
  output logic [W-1:0] count,
  output logic [W-1:0] count_nxt_c,
  output logic         wrap_c
);

  logic [W-1:0] count_q;

  assign wrap_c = en && (count_q == W'(MAX));

  always_comb begin
    count_nxt_c = count_q;
    if (en) begin
      count_nxt_c = (count_q == W'(MAX)) ? '0 : count_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!clr_n) count_q <= '0;
    else        count_q <= count_nxt_c;
  end

  assign count = count_q;

endmodule

// File: rtl/vga_timing.sv
// 640x480@60 VGA timing generator: 25 MHz pixel tick from 50 MHz clk, registered syncs.
// Define VGA_FRAME_CNT_EN to add the 8-bit frame counter output.
module vga_timing
  import vga_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  vga_if.master vga
);

  logic               pix_en;
  logic [COORD_W-1:0] xcnt, ycnt;
  logic [COORD_W-1:0] xcnt_nxt_c, ycnt_nxt_c;
  logic               hwrap_c, vwrap_c;
  logic               frame_wrap_c;
  vga_ctrl_t          ctrl_q;
  logic               frame_start_q;

  vga_wrap_counter #(.W(COORD_W), .MAX(H_TOTAL - 1)) u_hcnt (
    .clk         (clk),
    .clr_n       (rst_n),
    .en          (pix_en),
    .count       (xcnt),
    .count_nxt_c (xcnt_nxt_c),
    .wrap_c      (hwrap_c)
  );

  vga_wrap_counter #(.W(COORD_W), .MAX(V_TOTAL - 1)) u_vcnt (
    .clk         (clk),
    .clr_n       (rst_n),
    .en          (hwrap_c),
    .count       (ycnt),
    .count_nxt_c (ycnt_nxt_c),
    .wrap_c      (vwrap_c)
  );

  assign frame_wrap_c = hwrap_c && vwrap_c;

  // Decode the counters' next values so the registered flags line up with the coordinates.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pix_en        <= 1'b0;
      ctrl_q        <= '{hsync: 1'b1, vsync: 1'b1, nocolor: 1'b1};
      frame_start_q <= 1'b0;
    end else begin
      pix_en        <= ~pix_en;
      ctrl_q        <= vga_decode(xcnt_nxt_c, ycnt_nxt_c);
      frame_start_q <= frame_wrap_c;
    end
  end

`ifdef VGA_FRAME_CNT_EN
  logic [FRAME_CNT_W-1:0] frame_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) frame_cnt_q <= '0;
    else        frame_cnt_q <= frame_cnt_q + FRAME_CNT_W'(frame_wrap_c);
  end

  assign vga.frame_cnt = frame_cnt_q;
`endif

  assign vga.xcoord      = xcnt;
  assign vga.ycoord      = ycnt;
  assign vga.hsync       = ctrl_q.hsync;
  assign vga.vsync       = ctrl_q.vsync;
  assign vga.nocolor     = ctrl_q.nocolor;
  assign vga.frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing.sv
// Randomized bench for vga_timing: a clock-count model predicts every output each clk.
// Long scans are shortened by jumping the counters to chosen coordinates.
module tb_vga_timing;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  vga_if vif ();

  vga_timing dut (
    .clk   (clk),
    .rst_n (rst_n),
    .vga   (vif)
  );

  always #10 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  // Model state: clk edges since the last reset edge, wraps since reset, reset flag.
  longint unsigned c = 0;
  int unsigned     wraps = 0;
  bit              rst_last = 1'b1;
  logic [9:0]      fx, fy;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0d expected %0d", tag, $time, got, exp);
    end
  endtask

  function automatic longint unsigned pix(input longint unsigned cc);
    return cc / 2;
  endfunction

  function automatic bit wrap_now(input longint unsigned cc);
    return (cc > 0) && (cc % 2 == 0) && (pix(cc) % (800 * 525) == 0);
  endfunction

  task automatic check_outputs();
    longint unsigned p;
    int unsigned x, y;
    bit hs, vs, nc, fs;
    p  = pix(c);
    x  = int'(p % 800);
    y  = int'((p / 800) % 525);
    hs = !(x >= 656 && x <= 751);
    vs = !(y >= 490 && y <= 491);
    nc = (x >= 640) || (y >= 480);
    fs = !rst_last && wrap_now(c);
    if (rst_last) begin
      hs = 1'b1; vs = 1'b1; nc = 1'b1;
    end
    chk("xcoord", 32'(vif.xcoord), 32'(x));
    chk("ycoord", 32'(vif.ycoord), 32'(y));
    chk("hsync", 32'(vif.hsync), 32'(hs));
    chk("vsync", 32'(vif.vsync), 32'(vs));
    chk("nocolor", 32'(vif.nocolor), 32'(nc));
    chk("frame_start", 32'(vif.frame_start), 32'(fs));
`ifdef VGA_FRAME_CNT_EN
    chk("frame_cnt", 32'(vif.frame_cnt), 32'(wraps % 256));
`endif
  endtask

  // One clk: advance the model on the edge, then compare just after it.
  task automatic step();
    @(posedge clk);
    if (!rst_n) begin
      c = 0; wraps = 0; rst_last = 1'b1;
    end else begin
      c++; rst_last = 1'b0;
      if (wrap_now(c)) wraps++;
    end
    #1;
    check_outputs();
  endtask

  task automatic run(input int unsigned n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Place the counters at (x,y) between edges; pixel phase is preserved.
  task automatic jump(input int unsigned x, input int unsigned y);
    fx = 10'(x); fy = 10'(y);
    force dut.u_hcnt.count_q = fx;
    force dut.u_vcnt.count_q = fy;
    #1;
    release dut.u_hcnt.count_q;
    release dut.u_vcnt.count_q;
    c = 2 * (longint'(y) * 800 + longint'(x)) + (c % 2);
  endtask

  task automatic reset_pulse(input int unsigned n);
    rst_n = 1'b0;
    run(n);
    rst_n = 1'b1;
  endtask

  task automatic run_to_x(input int unsigned x);
    for (int i = 0; i < 2000; i++) begin
      if (pix(c) % 800 == x) return;
      step();
    end
    chk("run_to_x_timeout", 32'(pix(c) % 800), 32'(x));
  endtask

  initial begin
    reset_pulse(3);
    // First full line plus the start of the next.
    run(1700);
    chk("line1_y", 32'(vif.ycoord), 32'd1);
    // Horizontal sync window and wrap.
    jump(640, 3);  run(340);
    // Visible-area corner and blanking edges.
    jump(630, 479); run(40);
    jump(795, 479); run(20);
    // Vertical sync window.
    jump(799, 488); run(7000);
    // Frame wrap produces the single frame_start pulse.
    jump(790, 524); run(40);
    // Mid-frame reset at (300,100) abandons the frame.
    jump(290, 100); run_to_x(300);
    reset_pulse(1);
    chk("rst_mid_x", 32'(vif.xcoord), 32'd0);
    chk("rst_mid_fs", 32'(vif.frame_start), 32'd0);
    run(50);
    // Randomized jumps and resets.
    for (int k = 0; k < 30; k++) begin
      int unsigned rx, ry;
      rx = $urandom_range(799, 1);
      ry = $urandom_range(524, 0);
      if ($urandom_range(3, 0) == 0) begin
        rx = $urandom_range(799, 780);
        ry = 524;
      end
      jump(rx, ry);
      run($urandom_range(400, 1));
      if ($urandom_range(5, 0) == 0) begin
        reset_pulse($urandom_range(3, 1));
        run($urandom_range(20, 1));
      end
    end
`ifdef VGA_FRAME_CNT_EN
    reset_pulse(2);
    run(5);
    for (int k = 0; k < 256; k++) begin
      jump(797, 524);
      run(10);
      if (k == 2) chk("frame_cnt_3", 32'(vif.frame_cnt), 32'd3);
    end
    chk("frame_cnt_256", 32'(vif.frame_cnt), 32'd0);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
